// File: rtl/rv32i_mem_pkg.sv
// Shared definitions for the RV32I data-memory path: funct3 codes, LSU state
// encoding, default RAM size and the request legality check.
package rv32i_mem_pkg;

    localparam int MEM_SIZE_DFLT = 16384;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} lsu_state_e;

    // A request faults on an illegal funct3, a misaligned halfword/word,
    // or a word address beyond the last RAM word.
    function automatic logic is_fault(input logic        write,
                                      input logic [2:0]  funct3,
                                      input logic [31:0] addr,
                                      input int          mem_size);
        logic bad_f3;
        logic misaligned;
        logic out_of_range;
        bad_f3 = write ? !(funct3 inside {F3_B, F3_H, F3_W})
                       : !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        misaligned = ((funct3 == F3_H || funct3 == F3_HU) && addr[0])
                  || (funct3 == F3_W && addr[1:0] != 2'b00);
        out_of_range = {addr[31:2], 2'b00} > 32'(mem_size - 4);
        return bad_f3 || misaligned || out_of_range;
    endfunction

endpackage

// File: rtl/lsu_rmw_if.sv
// Core-side load/store request/response channel of the LSU.
interface lsu_rmw_if;
    import rv32i_mem_pkg::*;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_fault
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_fault
    );
endinterface

// File: rtl/lsu_align.sv
// Little-endian lane logic: sub-word load extraction/extension and
// sub-word store merge into a full RAM word.
module lsu_align
    import rv32i_mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] rdata_ext,
    output logic [31:0] merged
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        byte_lane = word[{addr_lo, 3'b000} +: 8];
        half_lane = addr_lo[1] ? word[31:16] : word[15:0];
        rdata_ext = word;
        merged    = word;
        case (funct3)
            F3_B: begin
                rdata_ext = {{24{byte_lane[7]}}, byte_lane};
                merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            end
            F3_H: begin
                rdata_ext = {{16{half_lane[15]}}, half_lane};
                merged[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
            end
            F3_W:    merged    = wdata;
            F3_BU:   rdata_ext = {24'h0, byte_lane};
            F3_HU:   rdata_ext = {16'h0, half_lane};
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_rmw.sv
// Load/store unit: word-only RAM initiator with read-modify-write for
// byte/halfword stores and fault detection on illegal requests.
module lsu_rmw
    import rv32i_mem_pkg::*;
#(
    parameter int MEM_SIZE = MEM_SIZE_DFLT
) (
    input  logic        clk,
    input  logic        rst,
    lsu_rmw_if.slave    bus,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    lsu_state_e  state;
    logic        write_q;
    logic [2:0]  f3_q;
    logic [1:0]  addr_lo_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        read_q;
    logic        write_en_q;
    logic        resp_valid_q;
    logic        resp_fault_q;
    logic [31:0] rdata_ext;
    logic [31:0] merged;

    lsu_align u_align (
        .funct3    (f3_q),
        .addr_lo   (addr_lo_q),
        .word      (rdata_q),
        .wdata     (wdata_q),
        .rdata_ext (rdata_ext),
        .merged    (merged)
    );

    // NOTE: sequential state uses non-blocking assignments only; reset clears
    // every register here, including the read-data and request latches.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            write_q      <= 1'b0;
            f3_q         <= 3'b000;
            addr_lo_q    <= 2'b00;
            wdata_q      <= 32'h0;
            rdata_q      <= 32'h0;
            read_q       <= 1'b0;
            write_en_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_fault_q <= 1'b0;
            mem_addr     <= 32'h0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid) begin
                    write_q   <= bus.req_write;
                    f3_q      <= bus.req_funct3;
                    addr_lo_q <= bus.req_addr[1:0];
                    wdata_q   <= bus.req_wdata;
                    if (is_fault(bus.req_write, bus.req_funct3, bus.req_addr, MEM_SIZE)) begin
                        state        <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_fault_q <= 1'b1;
                    end else if (!bus.req_write || bus.req_funct3 != F3_W) begin
                        state    <= RD;
                        read_q   <= 1'b1;
                        mem_addr <= {bus.req_addr[31:2], 2'b00};
                    end else begin
                        state      <= WR;
                        write_en_q <= 1'b1;
                        mem_addr   <= {bus.req_addr[31:2], 2'b00};
                    end
                end
                RD: begin
                    rdata_q <= mem_rdata;
                    read_q  <= 1'b0;
                    if (write_q) begin
                        state      <= WR;
                        write_en_q <= 1'b1;
                    end else begin
                        state        <= RESP;
                        resp_valid_q <= 1'b1;
                        mem_addr     <= 32'h0;
                    end
                end
                WR: begin
                    state        <= RESP;
                    write_en_q   <= 1'b0;
                    resp_valid_q <= 1'b1;
                    mem_addr     <= 32'h0;
                end
                RESP: begin
                    state        <= IDLE;
                    resp_valid_q <= 1'b0;
                    resp_fault_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes are cut by rst so an aborted WR never reaches the RAM.
    assign mem_read       = read_q && !rst;
    assign mem_write      = write_en_q && !rst;
    assign mem_wdata      = (state == WR) ? merged : 32'h0;
    assign bus.req_ready  = !rst && (state == IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_fault = resp_fault_q;
    assign bus.resp_rdata = (state == RESP && !write_q && !resp_fault_q) ? rdata_ext : 32'h0;

endmodule

// File: tb/tb_lsu_rmw.sv
// Directed bench for lsu_rmw with a behavioural word RAM on the data port.
module tb_lsu_rmw;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] ram [0:4095];
    logic        poke_en = 1'b0;
    logic [11:0] poke_idx = '0;
    logic [31:0] poke_val = '0;
    int          strobe_cnt = 0;
    int          vectors = 0;
    int          miscompares = 0;
    int          strobe_ref;

    lsu_rmw_if bus ();

    lsu_rmw u_dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .mem_addr  (mem_addr),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = ram[mem_addr[13:2]];

    always @(posedge clk) begin
        if (mem_write)    ram[mem_addr[13:2]] <= mem_wdata;
        else if (poke_en) ram[poke_idx] <= poke_val;
        if (mem_read || mem_write) strobe_cnt <= strobe_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [11:0] idx, input logic [31:0] val);
        poke_en  = 1'b1;
        poke_idx = idx;
        poke_val = val;
        tick();
        poke_en  = 1'b0;
    endtask

    // Present one request for a single accept edge, then scramble the fields.
    task automatic issue(input logic write, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata);
        bus.req_valid  = 1'b1;
        bus.req_write  = write;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        tick();
        bus.req_valid  = 1'b0;
        bus.req_write  = ~write;
        bus.req_funct3 = 3'b111;
        bus.req_addr   = 32'hFFFF_FFFF;
        bus.req_wdata  = 32'h0;
        #1;
    endtask

    task automatic load(input string tag, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] exp);
        issue(1'b0, f3, addr, 32'h0);
        check({tag, "_rd"}, {31'h0, mem_read}, 32'h1);
        tick();
        check({tag, "_valid"}, {31'h0, bus.resp_valid}, 32'h1);
        check({tag, "_rdata"}, bus.resp_rdata, exp);
        tick();
    endtask

    task automatic fault(input string tag, input logic write, input logic [2:0] f3,
                         input logic [31:0] addr);
        strobe_ref = strobe_cnt;
        issue(write, f3, addr, 32'h1234_5678);
        check({tag, "_valid"}, {31'h0, bus.resp_valid}, 32'h1);
        check({tag, "_fault"}, {31'h0, bus.resp_fault}, 32'h1);
        check({tag, "_rdata"}, bus.resp_rdata, 32'h0);
        tick();
        check({tag, "_strobes"}, 32'(strobe_cnt), 32'(strobe_ref));
        check({tag, "_ready"}, {31'h0, bus.req_ready}, 32'h1);
    endtask

    initial begin
        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        repeat (3) tick();

        check("rst_ready",      {31'h0, bus.req_ready},  32'h0);
        check("rst_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
        check("rst_resp_fault", {31'h0, bus.resp_fault}, 32'h0);
        check("rst_resp_rdata", bus.resp_rdata,          32'h0);
        check("rst_mem_strobe", {30'h0, mem_read, mem_write}, 32'h0);
        check("rst_mem_addr",   mem_addr,                32'h0);
        check("rst_mem_wdata",  mem_wdata,               32'h0);

        rst = 1'b0;
        poke(12'd4, 32'hDEAD_BEEF);
        check("ready_after_rst", {31'h0, bus.req_ready}, 32'h1);

        // LW at 0x10, checking the RD cycle in detail
        issue(1'b0, 3'b010, 32'h10, 32'h0);
        check("lw_mem_read",  {31'h0, mem_read},       32'h1);
        check("lw_mem_addr",  mem_addr,                32'h10);
        check("lw_no_valid",  {31'h0, bus.resp_valid}, 32'h0);
        tick();
        check("lw_valid",     {31'h0, bus.resp_valid}, 32'h1);
        check("lw_rdata",     bus.resp_rdata,          32'hDEAD_BEEF);
        check("lw_fault",     {31'h0, bus.resp_fault}, 32'h0);
        check("lw_mem_addr0", mem_addr,                32'h0);
        tick();
        check("lw_ready",     {31'h0, bus.req_ready},  32'h1);
        check("lw_pulse",     {31'h0, bus.resp_valid}, 32'h0);

        poke(12'd4, 32'h8011_2233);
        load("lb13",  3'b000, 32'h13, 32'hFFFF_FF80);
        load("lbu13", 3'b100, 32'h13, 32'h0000_0080);
        load("lh12",  3'b001, 32'h12, 32'hFFFF_8011);
        load("lhu12", 3'b101, 32'h12, 32'h0000_8011);
        load("lb10",  3'b000, 32'h10, 32'h0000_0033);
        load("lh10",  3'b001, 32'h10, 32'h0000_2233);

        // SB 0xAA at 0x11: read-modify-write of the word at 0x10
        poke(12'd4, 32'h1122_3344);
        issue(1'b1, 3'b000, 32'h11, 32'h1234_56AA);
        check("sb_rd",        {30'h0, mem_read, mem_write}, 32'h2);
        check("sb_rd_addr",   mem_addr,                32'h10);
        tick();
        check("sb_wr",        {30'h0, mem_read, mem_write}, 32'h1);
        check("sb_wr_addr",   mem_addr,                32'h10);
        check("sb_wdata",     mem_wdata,               32'h1122_AA44);
        check("sb_no_valid",  {31'h0, bus.resp_valid}, 32'h0);
        tick();
        check("sb_valid",     {31'h0, bus.resp_valid}, 32'h1);
        check("sb_rdata",     bus.resp_rdata,          32'h0);
        check("sb_ram",       ram[4],                  32'h1122_AA44);
        tick();

        issue(1'b1, 3'b001, 32'h12, 32'h9999_BEEF);
        tick();
        check("sh_wdata",     mem_wdata,               32'hBEEF_AA44);
        tick();
        check("sh_valid",     {31'h0, bus.resp_valid}, 32'h1);
        check("sh_ram",       ram[4],                  32'hBEEF_AA44);
        tick();

        // SW goes straight to WR without a read
        issue(1'b1, 3'b010, 32'h20, 32'hCAFE_F00D);
        check("sw_strobes",   {30'h0, mem_read, mem_write}, 32'h1);
        check("sw_addr",      mem_addr,                32'h20);
        check("sw_wdata",     mem_wdata,               32'hCAFE_F00D);
        tick();
        check("sw_valid",     {31'h0, bus.resp_valid}, 32'h1);
        check("sw_ram",       ram[8],                  32'hCAFE_F00D);
        tick();

        poke(12'd4095, 32'h0BAD_F00D);
        load("lw_last", 3'b010, 32'h3FFC, 32'h0BAD_F00D);

        fault("lh_odd",   1'b0, 3'b001, 32'h11);
        fault("lw_3ffe",  1'b0, 3'b010, 32'h3FFE);
        fault("lw_4000",  1'b0, 3'b010, 32'h4000);
        fault("ld_f3_011", 1'b0, 3'b011, 32'h10);
        fault("st_f3_100", 1'b1, 3'b100, 32'h10);

        // Reset during the WR cycle of an SB abandons the store
        poke(12'd4, 32'h1122_3344);
        issue(1'b1, 3'b000, 32'h10, 32'h0000_0055);
        tick();
        rst = 1'b1;
        #1;
        check("abort_no_write", {31'h0, mem_write},    32'h0);
        tick();
        check("abort_no_valid", {31'h0, bus.resp_valid}, 32'h0);
        check("abort_ready_rst", {31'h0, bus.req_ready}, 32'h0);
        rst = 1'b0;
        #1;
        check("abort_ready",    {31'h0, bus.req_ready}, 32'h1);
        check("abort_ram",      ram[4],                32'h1122_3344);
        tick();
        check("abort_no_resp",  {31'h0, bus.resp_valid}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lsu_rmw.md
# lsu_rmw

Load/store unit for the single-cycle-derived RV32I core. It is the initiator on the data port of the 16 KB byte-addressed RAM. The core issues one load/store request at a time. The RAM port is word-only (4-byte write, 4-byte combinational read), so this unit generates word-aligned accesses, performs read-modify-write for byte/halfword stores, extracts and extends sub-word loads, and flags misaligned or out-of-range accesses.

## Interface
- MEM_SIZE, 16384, RAM size in bytes; legal word addresses are 0..MEM_SIZE-4.
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  core presents a request.
- req_ready  out  1  unit accepts a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 of the load/store.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result, extended; 0 for stores and faults.
- resp_fault  out  1  misaligned, out-of-range, or illegal funct3.
- mem_addr  out  32  RAM data address, always word-aligned.
- mem_read  out  1  RAM read enable.
- mem_write  out  1  RAM write enable; the RAM commits on the rising edge.
- mem_wdata  out  32  RAM write data.
- mem_rdata  in  32  RAM read data, combinational from mem_addr.

## Operation
- States:
  - IDLE: req_ready=1; no memory strobes.
  - RD: mem_read=1; mem_rdata is registered at the cycle end.
  - WR: mem_write=1.
  - RESP: resp_valid=1.
- Accept: req_valid && req_ready in IDLE. Request fields are latched.
- Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Legal stores: 000 SB, 001 SH, 010 SW.
- Fault cases, with transition IDLE→RESP, resp_fault=1, rdata 0, no strobes:
  - any other funct3;
  - halfword at an odd address;
  - word with addr[1:0]≠0;
  - aligned word address > MEM_SIZE-4.
- Transitions:
  - load: IDLE→RD→RESP.
  - SW: IDLE→WR→RESP.
  - SB/SH: IDLE→RD→WR→RESP.
  - RESP→IDLE, always.
- mem_addr = {addr[31:2],2'b00} during RD/WR, and 0 otherwise.
- Lanes are little-endian.
  - Byte lane = addr[1:0]; halfword lane = addr[1].
- Loads: extract the lane.
  - LB/LH sign-extend.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- Sub-word stores: mem_wdata = registered read word with the lane replaced by req_wdata[7:0] or [15:0]. Other bytes are unchanged.
- SW: mem_wdata = req_wdata.

## Timing
- Reset values:
  - state=IDLE;
  - resp_valid=0, resp_fault=0, resp_rdata=0;
  - mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
- req_ready=0 while rst is high, and (state==IDLE) otherwise.
- Latency from the accept edge to resp_valid:
  - loads: 2 cycles;
  - SW: 2 cycles;
  - SB/SH: 3 cycles;
  - fault: 1 cycle.
- resp_valid is a single-cycle pulse with no backpressure. The core must sample it.
- No request is accepted in RESP. Back-to-back throughput is one request per 3/3/4/2 cycles (loads/SW/SB-SH/fault).
- mem_read and mem_write are gated by !rst, so no RAM write occurs in any cycle where rst is high.
- Reset mid-operation abandons the request: next state IDLE, no response is issued, and RAM contents from the aborted WR are unchanged.
- req_* fields may change freely after accept. Latched copies are used.

## Structure
- Shared package rv32i_mem_pkg holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - lsu state encoding (IDLE, RD, WR, RESP);
  - MEM_SIZE default.
- One combinational sub-module, lsu_align. It does load lane extraction/extension and store lane merge. Inputs: funct3, addr[1:0], word, wdata. Outputs: rdata_ext, merged.
- lsu_rmw holds the FSM, request latch, and read-data register.

## Test plan
- Reset: hold rst 3 cycles → all outputs 0, req_ready=0. Release rst → req_ready=1 next cycle.
- LW at 0x10, mem word 0xDEADBEEF → RD drives mem_addr=0x10, mem_read=1. resp_valid at accept+2 with rdata 0xDEADBEEF, fault 0.
- Word 0x80112233 at 0x10:
  - LB at 0x13 → rdata 0xFFFFFF80.
  - LBU at 0x13 → 0x00000080.
  - LH at 0x12 → 0xFFFF8011.
- SB 0xAA at 0x11 over 0x11223344 → RD, then WR with mem_addr=0x10, mem_wdata=0x1122AA44. resp at accept+3. SW at 0x20 → no mem_read, WR at accept+1.
- LH at 0x11, LW at 0x3FFE, LW at 0x4000, funct3 011 → resp_fault=1 at accept+1, mem_read/mem_write never asserted.
- SB issued, rst asserted during the WR cycle → mem_write=0 that cycle, RAM word unchanged, no resp_valid, req_ready=1 the cycle after rst drops.
